// File: rtl/if_id_buffer.sv
// Fetch/decode pipeline register: splits 16-bit words into fields and assembles two-word immediate instructions.
// Optional macro IFID_PERF_CNT_EN adds saturating issued/bubble counters.
//
// state  | meaning
// FIRST  | expecting an opcode word
// SECOND | first word of an immediate-class instruction held, waiting for the immediate word
module if_id_buffer #(
    parameter logic [2:0] IMM_CLASS = 3'b101,
    parameter int         PC_W      = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [15:0]     inst_in,
    input  logic [PC_W-1:0] pc_in,
    input  logic            stall,
    input  logic            flush,
    output logic            out_valid,
    output logic [4:0]      opCode,
    output logic [2:0]      Rs,
    output logic [2:0]      Rd,
    output logic [4:0]      SHMNT,
    output logic [15:0]     imm,
    output logic            isImmediate,
    output logic [PC_W-1:0] pc_out,
`ifdef IFID_PERF_CNT_EN
    output logic [15:0]     issued_cnt,
    output logic [15:0]     bubble_cnt,
`endif
    output logic            LDM_signal
);

    typedef enum logic {FIRST, SECOND} state_t;

    state_t state, state_nxt;

    logic [15:0]     hold_inst, hold_inst_d;
    logic [PC_W-1:0] hold_pc, hold_pc_d;

    logic            out_valid_d;
    logic [4:0]      opcode_d;
    logic [2:0]      rs_d;
    logic [2:0]      rd_d;
    logic [4:0]      shmnt_d;
    logic [15:0]     imm_d;
    logic            is_imm_d;
    logic [PC_W-1:0] pc_d;
    logic            ldm_d;

    logic            first_is_imm;

    assign first_is_imm = (inst_in[15:13] == IMM_CLASS);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FIRST;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = FIRST;
        end else if (!stall && in_valid) begin
            case (state)
                FIRST:   state_nxt = first_is_imm ? SECOND : FIRST;
                SECOND:  state_nxt = FIRST;
                default: state_nxt = FIRST;
            endcase
        end
    end

    // Next values of the registered outputs; default is to hold everything.
    always_comb begin
        out_valid_d = out_valid;
        opcode_d    = opCode;
        rs_d        = Rs;
        rd_d        = Rd;
        shmnt_d     = SHMNT;
        imm_d       = imm;
        is_imm_d    = isImmediate;
        pc_d        = pc_out;
        ldm_d       = LDM_signal;
        hold_inst_d = hold_inst;
        hold_pc_d   = hold_pc;
        if (flush) begin
            out_valid_d = 1'b0;
            is_imm_d    = 1'b0;
            ldm_d       = 1'b0;
            hold_inst_d = '0;
            hold_pc_d   = '0;
        end else if (!stall) begin
            out_valid_d = 1'b0;
            if (in_valid) begin
                case (state)
                    FIRST: begin
                        if (first_is_imm) begin
                            hold_inst_d = inst_in;
                            hold_pc_d   = pc_in;
                            ldm_d       = 1'b1;
                        end else begin
                            opcode_d    = inst_in[15:11];
                            rs_d        = inst_in[10:8];
                            rd_d        = inst_in[7:5];
                            shmnt_d     = inst_in[4:0];
                            imm_d       = '0;
                            is_imm_d    = 1'b0;
                            pc_d        = pc_in;
                            out_valid_d = 1'b1;
                        end
                    end
                    SECOND: begin
                        // Second word is raw immediate data, never decoded.
                        opcode_d    = hold_inst[15:11];
                        rs_d        = hold_inst[10:8];
                        rd_d        = hold_inst[7:5];
                        shmnt_d     = hold_inst[4:0];
                        imm_d       = inst_in;
                        is_imm_d    = 1'b1;
                        pc_d        = hold_pc;
                        out_valid_d = 1'b1;
                        ldm_d       = 1'b0;
                    end
                    default: begin
                        out_valid_d = 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            opCode      <= '0;
            Rs          <= '0;
            Rd          <= '0;
            SHMNT       <= '0;
            imm         <= '0;
            isImmediate <= 1'b0;
            pc_out      <= '0;
            LDM_signal  <= 1'b0;
            hold_inst   <= '0;
            hold_pc     <= '0;
        end else begin
            out_valid   <= out_valid_d;
            opCode      <= opcode_d;
            Rs          <= rs_d;
            Rd          <= rd_d;
            SHMNT       <= shmnt_d;
            imm         <= imm_d;
            isImmediate <= is_imm_d;
            pc_out      <= pc_d;
            LDM_signal  <= ldm_d;
            hold_inst   <= hold_inst_d;
            hold_pc     <= hold_pc_d;
        end
    end

`ifdef IFID_PERF_CNT_EN
    // A flush overrides a concurrent stall, so that edge counts as a bubble.
    logic cnt_live;
    assign cnt_live = flush || !stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            issued_cnt <= '0;
            bubble_cnt <= '0;
        end else if (cnt_live) begin
            if (out_valid_d) begin
                if (issued_cnt != 16'hFFFF) issued_cnt <= issued_cnt + 16'd1;
            end else begin
                if (bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Scoreboard bench for if_id_buffer: expected bundles are queued at issue time and popped by a monitor.
module tb_if_id_buffer;

    localparam int PC_W = 32;

    logic            clk;
    logic            reset;
    logic            in_valid;
    logic [15:0]     inst_in;
    logic [PC_W-1:0] pc_in;
    logic            stall;
    logic            flush;
    logic            out_valid;
    logic [4:0]      opCode;
    logic [2:0]      Rs;
    logic [2:0]      Rd;
    logic [4:0]      SHMNT;
    logic [15:0]     imm;
    logic            isImmediate;
    logic [PC_W-1:0] pc_out;
    logic            LDM_signal;
`ifdef IFID_PERF_CNT_EN
    logic [15:0]     issued_cnt;
    logic [15:0]     bubble_cnt;
`endif

    if_id_buffer #(.IMM_CLASS(3'b101), .PC_W(PC_W)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .inst_in(inst_in),
        .pc_in(pc_in),
        .stall(stall),
        .flush(flush),
        .out_valid(out_valid),
        .opCode(opCode),
        .Rs(Rs),
        .Rd(Rd),
        .SHMNT(SHMNT),
        .imm(imm),
        .isImmediate(isImmediate),
        .pc_out(pc_out),
`ifdef IFID_PERF_CNT_EN
        .issued_cnt(issued_cnt),
        .bubble_cnt(bubble_cnt),
`endif
        .LDM_signal(LDM_signal)
    );

    typedef struct {
        logic [4:0]  op;
        logic [2:0]  rs;
        logic [2:0]  rd;
        logic [4:0]  sh;
        logic [15:0] im;
        logic        isimm;
        logic [31:0] pc;
    } bundle_t;

    bundle_t exp_q[$];
    int checks = 0;
    int errors = 0;
    logic edge_live = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_bundle(input logic [4:0] op, input logic [2:0] rs, input logic [2:0] rd,
                                 input logic [4:0] sh, input logic [15:0] im, input logic isimm,
                                 input logic [31:0] pc);
        bundle_t b;
        b.op = op; b.rs = rs; b.rd = rd; b.sh = sh; b.im = im; b.isimm = isimm; b.pc = pc;
        exp_q.push_back(b);
    endtask

    task automatic step(input logic v, input logic [15:0] w, input logic [31:0] p,
                        input logic st = 1'b0, input logic fl = 1'b0, input logic rs = 1'b0);
        in_valid = v;
        inst_in  = w;
        pc_in    = p;
        stall    = st;
        flush    = fl;
        reset    = rs;
        @(posedge clk);
        #1;
    endtask

    // A bundle is new only if the edge that produced it actually captured.
    always @(posedge clk) edge_live <= !reset && !flush && !stall;

    always @(negedge clk) begin
        if (edge_live && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_bundle: got pc %0h expected none", pc_out);
            end else begin
                bundle_t e;
                e = exp_q.pop_front();
                check("sb_opCode", 32'(opCode), 32'(e.op));
                check("sb_Rs", 32'(Rs), 32'(e.rs));
                check("sb_Rd", 32'(Rd), 32'(e.rd));
                check("sb_SHMNT", 32'(SHMNT), 32'(e.sh));
                check("sb_imm", 32'(imm), 32'(e.im));
                check("sb_isImmediate", 32'(isImmediate), 32'(e.isimm));
                check("sb_pc_out", pc_out, e.pc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; inst_in = '0; pc_in = '0; stall = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_ldm", 32'(LDM_signal), 32'd0);
        check("rst_opCode", 32'(opCode), 32'd0);
        check("rst_imm", 32'(imm), 32'd0);
        check("rst_pc_out", pc_out, 32'd0);
        check("rst_isImmediate", 32'(isImmediate), 32'd0);

        // Single word
        expect_bundle(5'h01, 3'd3, 3'd2, 5'd5, 16'h0000, 1'b0, 32'h20);
        step(1'b1, 16'h0B45, 32'h20);

        // Two-word
        step(1'b1, 16'hA0E0, 32'h30);
        check("tw_bubble_valid", 32'(out_valid), 32'd0);
        check("tw_ldm_high", 32'(LDM_signal), 32'd1);
        expect_bundle(5'h14, 3'd0, 3'd7, 5'd0, 16'h1234, 1'b1, 32'h30);
        step(1'b1, 16'h1234, 32'h32);
        check("tw_ldm_drop", 32'(LDM_signal), 32'd0);

        // Two-word with stall in SECOND
        step(1'b1, 16'hB3A9, 32'h40);
        check("st_ldm_high", 32'(LDM_signal), 32'd1);
        step(1'b1, 16'h1111, 32'h42, 1'b1);
        step(1'b1, 16'h2222, 32'h42, 1'b1);
        step(1'b1, 16'h3333, 32'h42, 1'b1);
        check("st_frozen_valid", 32'(out_valid), 32'd0);
        check("st_frozen_ldm", 32'(LDM_signal), 32'd1);
        check("st_frozen_imm", 32'(imm), 32'h1234);
        check("st_frozen_pc", pc_out, 32'h30);
        check("st_frozen_op", 32'(opCode), 32'h14);
        expect_bundle(5'h16, 3'd3, 3'd5, 5'd9, 16'hBEEF, 1'b1, 32'h40);
        step(1'b1, 16'hBEEF, 32'h42);

        // Flush mid-assembly drops the half instruction
        step(1'b1, 16'hA0E0, 32'h50);
        step(1'b1, 16'h5555, 32'h52, 1'b0, 1'b1);
        check("fl_valid", 32'(out_valid), 32'd0);
        check("fl_ldm", 32'(LDM_signal), 32'd0);
        check("fl_isImmediate", 32'(isImmediate), 32'd0);
        expect_bundle(5'h01, 3'd3, 3'd2, 5'd5, 16'h0000, 1'b0, 32'h58);
        step(1'b1, 16'h0B45, 32'h58);

        // Flush beats stall
        step(1'b1, 16'hA0E0, 32'h60);
        step(1'b1, 16'h5555, 32'h62, 1'b1, 1'b1);
        check("fs_valid", 32'(out_valid), 32'd0);
        check("fs_ldm", 32'(LDM_signal), 32'd0);
        expect_bundle(5'h01, 3'd3, 3'd2, 5'd5, 16'h0000, 1'b0, 32'h64);
        step(1'b1, 16'h0B45, 32'h64);

        // SECOND waits through idle cycles
        step(1'b1, 16'hA0E0, 32'h70);
        step(1'b0, 16'hFFFF, 32'h0);
        check("wait_valid", 32'(out_valid), 32'd0);
        check("wait_ldm", 32'(LDM_signal), 32'd1);
        expect_bundle(5'h14, 3'd0, 3'd7, 5'd0, 16'h00FF, 1'b1, 32'h70);
        step(1'b1, 16'h00FF, 32'h74);

        // NOP, and an imm-class pattern taken as immediate data
        expect_bundle(5'h00, 3'd0, 3'd0, 5'd0, 16'h0000, 1'b0, 32'h80);
        step(1'b1, 16'h0000, 32'h80);
        step(1'b1, 16'hA0E0, 32'h90);
        expect_bundle(5'h14, 3'd0, 3'd7, 5'd0, 16'hB3A9, 1'b1, 32'h90);
        step(1'b1, 16'hB3A9, 32'h92);
        check("imm_pattern_ldm", 32'(LDM_signal), 32'd0);

        // Idle in FIRST keeps fields
        step(1'b0, 16'h0B45, 32'hEE);
        check("idle_valid", 32'(out_valid), 32'd0);
        check("idle_opCode", 32'(opCode), 32'h14);
        check("idle_imm", 32'(imm), 32'hB3A9);
        check("idle_pc", pc_out, 32'h90);

        // Reset mid-assembly
        step(1'b1, 16'hA0E0, 32'hA0);
        step(1'b1, 16'h1234, 32'hA2, 1'b0, 1'b0, 1'b1);
        check("rm_valid", 32'(out_valid), 32'd0);
        check("rm_ldm", 32'(LDM_signal), 32'd0);
        check("rm_opCode", 32'(opCode), 32'd0);
        check("rm_imm", 32'(imm), 32'd0);
        check("rm_pc", pc_out, 32'd0);
        expect_bundle(5'h01, 3'd3, 3'd2, 5'd5, 16'h0000, 1'b0, 32'hA4);
        step(1'b1, 16'h0B45, 32'hA4);

`ifdef IFID_PERF_CNT_EN
        step(1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        check("pc_rst_issued", 32'(issued_cnt), 32'd0);
        check("pc_rst_bubble", 32'(bubble_cnt), 32'd0);
        expect_bundle(5'h01, 3'd3, 3'd2, 5'd5, 16'h0000, 1'b0, 32'hC0);
        step(1'b1, 16'h0B45, 32'hC0);
        expect_bundle(5'h01, 3'd3, 3'd2, 5'd5, 16'h0000, 1'b0, 32'hC2);
        step(1'b1, 16'h0B45, 32'hC2);
        expect_bundle(5'h00, 3'd0, 3'd0, 5'd0, 16'h0000, 1'b0, 32'hC4);
        step(1'b1, 16'h0000, 32'hC4);
        step(1'b1, 16'hA0E0, 32'hC6);
        step(1'b1, 16'h7777, 32'hC8, 1'b1);
        step(1'b1, 16'h8888, 32'hC8, 1'b1);
        expect_bundle(5'h14, 3'd0, 3'd7, 5'd0, 16'h4242, 1'b1, 32'hC6);
        step(1'b1, 16'h4242, 32'hC8);
        check("perf_issued", 32'(issued_cnt), 32'd4);
        check("perf_bubble", 32'(bubble_cnt), 32'd1);
`endif

        in_valid = 1'b0;
        @(negedge clk);
        #1;
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_buffer.md
Name: if_id_buffer

Overview:
- Pipeline register between the fetch stage and the decode stage.
- Registers each fetched 16-bit instruction word with its PC and splits it into opCode, Rs, Rd and SHMNT fields.
- Assembles two-word (immediate-class) instructions: holds the first word, captures the following word as the 16-bit immediate, and emits both as one decoded bundle.
- Drives the bubble-request signal back to fetch; honours stall and flush from hazard and branch logic.

Parameters:
- IMM_CLASS, 3'b101, value of opCode[4:2] that marks a two-word instruction.
- PC_W, 32, PC width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  fetch presents a valid word this cycle
- inst_in  input  16  fetched word: [15:11] opCode, [10:8] Rs, [7:5] Rd, [4:0] SHMNT
- pc_in  input  PC_W  PC of inst_in
- stall  input  1  freeze buffer contents and state
- flush  input  1  discard contents (taken branch, jump, interrupt)
- out_valid  output  1  decoded bundle valid for decode
- opCode  output  5  decoded opcode
- Rs  output  3  source register
- Rd  output  3  destination register
- SHMNT  output  5  shift amount
- imm  output  16  immediate (second word); 0 for single-word instructions
- isImmediate  output  1  bundle is a two-word instruction
- pc_out  output  PC_W  PC of the first word
- LDM_signal  output  1  high while waiting for the immediate word; fetch inserts a bubble

Behaviour:
- Reset: all outputs 0; state FIRST; holding registers cleared.
- Priority: reset > flush > stall > normal capture.
- State FIRST, in_valid=1, opCode field not IMM_CLASS:
  - Next edge registers the fields, imm=0, isImmediate=0, pc_out=pc_in, out_valid=1.
  - Latency is 1 cycle.
- State FIRST, in_valid=1, inst_in[15:13]==IMM_CLASS:
  - Word and pc_in go to the holding registers.
  - out_valid=0 (bubble); state goes to SECOND; LDM_signal=1 from the next cycle.
- State SECOND, in_valid=1:
  - inst_in is taken as imm regardless of its bit pattern.
  - Outputs show the held fields, isImmediate=1, pc_out = held PC, out_valid=1.
  - State returns to FIRST; LDM_signal drops.
  - Total latency from the first word is 2 cycles.
- State SECOND, in_valid=0: remain in SECOND with out_valid=0 and LDM_signal held at 1.
- in_valid=0 in FIRST: out_valid=0, other outputs keep their last values.
- stall=1:
  - All outputs, holding registers and state are unchanged.
  - inst_in is ignored, even in SECOND.
  - LDM_signal keeps its value.
- flush=1:
  - out_valid=0, isImmediate=0, LDM_signal=0, state FIRST, holding registers cleared.
  - A half-assembled two-word instruction is dropped.
  - The word presented in the same cycle is discarded.
- Flush together with stall: flush wins.
- A word whose opCode field is all zero passes as a normal single-word bundle (NOP); no special case.
- pc_out is never incremented in this block.
- Reset mid-assembly: behaves as flush plus all outputs forced to 0.

Optional Feature:
- Macro IFID_PERF_CNT_EN adds two outputs:
  - issued_cnt [15:0]: increments on every cycle with out_valid=1.
  - bubble_cnt [15:0]: increments on every cycle with out_valid=0 that is not a stall.
- Both counters saturate at 16'hFFFF; they clear on reset only (not on flush); stall freezes them.
- Without the macro the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset then single word 16'h0B45 at pc 0x20 -> next cycle out_valid=1, opCode=5'h01, Rs=3, Rd=2, SHMNT=5, imm=0, pc_out=0x20.
- Word 16'hA0E0 (opCode[4:2]=101) at pc 0x30, then 16'h1234 -> cycle 1: out_valid=0, LDM_signal=1; cycle 2: out_valid=1, isImmediate=1, opCode=5'h14, Rd=7, imm=16'h1234, pc_out=0x30, LDM_signal=0.
- Two-word start, then stall=1 for 3 cycles with changing inst_in, then 16'hBEEF -> outputs frozen during the stall; bundle then emitted with imm=16'hBEEF.
- Two-word start, then flush=1 with 16'h5555 presented -> out_valid=0, LDM_signal=0; the next word 16'h0B45 decodes as single-word, not as an immediate.
- flush and stall asserted together on a valid word -> out_valid=0, state FIRST.
- With IFID_PERF_CNT_EN: 3 single-word instructions, 1 two-word instruction, 2 stall cycles -> issued_cnt=4, bubble_cnt=1.
